// File: rtl/irq_gw_pkg.sv
// Shared types and helpers for the irq_gw_arb interrupt gateway/arbiter.
package irq_gw_pkg;

  typedef enum logic [1:0] {
    GwIdle   = 2'd0,
    GwPend   = 2'd1,
    GwActive = 2'd2
  } gw_state_e;

  localparam int unsigned IdNone = 0;

  function automatic int unsigned id_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/irq_gw_src.sv
// Per-source interrupt gateway: edge/level trigger, IDLE/PEND/ACTIVE FSM and re-arm bit.
// With IRQ_GW_CLAIM_TIMEOUT_EN defined, adds a claim watchdog counter per source.
module irq_gw_src
  import irq_gw_pkg::*;
#(
  parameter int unsigned TimeoutW = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  input  logic edge_mode_i,
  input  logic claim_i,
  input  logic complete_i,
`ifdef IRQ_GW_CLAIM_TIMEOUT_EN
  input  logic timeout_grant_i,
  output logic expired_o,
`endif
  output logic pending_o,
  output logic active_o
);

  gw_state_e state_q, state_d;
  logic      rearm_q, rearm_d;
  logic      src_q, src_d;
  logic      trigger;
  logic      done;

  assign src_d   = src_i;
  assign trigger = edge_mode_i ? (src_i & ~src_q) : src_i;

`ifdef IRQ_GW_CLAIM_TIMEOUT_EN
  logic [TimeoutW-1:0] cnt_q, cnt_d;

  assign done      = complete_i | timeout_grant_i;
  assign expired_o = (state_q == GwActive) && (cnt_q == '1);

  // Saturates at all-ones so an expiry that loses arbitration stays visible.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != GwActive) begin
      cnt_d = '0;
    end else if ((state_q == GwActive) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign done = complete_i;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= GwIdle;
      rearm_q <= 1'b0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rearm_q <= rearm_d;
      src_q   <= src_d;
    end
  end

  // NOTE: defaults first keep every path assigned, so no latches are inferred.
  always_comb begin
    state_d = state_q;
    rearm_d = rearm_q;
    unique case (state_q)
      GwIdle: begin
        if (trigger) state_d = GwPend;
      end
      GwPend: begin
        if (claim_i) begin
          state_d = GwActive;
          rearm_d = edge_mode_i & trigger;
        end
      end
      GwActive: begin
        if (done) begin
          state_d = (rearm_q || (edge_mode_i && trigger)) ? GwPend : GwIdle;
          rearm_d = 1'b0;
        end else if (edge_mode_i && trigger) begin
          rearm_d = 1'b1;
        end
      end
      default: state_d = GwIdle;
    endcase
  end

  always_comb begin
    pending_o = (state_q == GwPend);
    active_o  = (state_q == GwActive);
  end

endmodule

// File: rtl/irq_gw_arb.sv
// Interrupt gateway bank plus priority arbiter with claim/complete handshake.
// Optional claim watchdog enabled by defining IRQ_GW_CLAIM_TIMEOUT_EN.
module irq_gw_arb
  import irq_gw_pkg::*;
#(
  parameter  int unsigned NumSrc    = 4,
  parameter  int unsigned PrioWidth = 2,
  parameter  int unsigned TimeoutW  = 8,
  localparam int unsigned IdW       = id_width(NumSrc)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumSrc-1:0]           intr_src_i,
  input  logic [NumSrc-1:0]           edge_mode_i,
  input  logic [NumSrc-1:0]           ie_i,
  input  logic [NumSrc*PrioWidth-1:0] prio_i,
  input  logic [PrioWidth-1:0]        threshold_i,
  input  logic                        claim_req_i,
  output logic [IdW-1:0]              claim_id_o,
  output logic                        claim_valid_o,
  input  logic                        complete_i,
  input  logic [IdW-1:0]              complete_id_i,
  output logic                        irq_o,
  output logic                        timeout_o
);

  logic [PrioWidth-1:0] prio_of [NumSrc];
  logic [NumSrc-1:0]    pending, active, eligible, claim_hit, complete_hit;
  logic [IdW-1:0]       best_id;
  logic [PrioWidth-1:0] best_prio;

  logic           irq_q, irq_d;
  logic           claim_valid_q, claim_valid_d;
  logic [IdW-1:0] claim_id_q, claim_id_d;

`ifdef IRQ_GW_CLAIM_TIMEOUT_EN
  logic [NumSrc-1:0] expired, timeout_grant;
  logic              timeout_q, timeout_d;
`endif

  for (genvar g = 0; g < NumSrc; g++) begin : g_src
    assign prio_of[g]      = prio_i[g*PrioWidth +: PrioWidth];
    assign eligible[g]     = pending[g] && ie_i[g] && (prio_of[g] > threshold_i);
    assign claim_hit[g]    = claim_req_i && (best_id == IdW'(g + 1));
    // IDs 0 and > NumSrc match no source, so such completes fall through.
    assign complete_hit[g] = complete_i && (complete_id_i == IdW'(g + 1));

    irq_gw_src #(.TimeoutW(TimeoutW)) u_src (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .src_i           (intr_src_i[g]),
      .edge_mode_i     (edge_mode_i[g]),
      .claim_i         (claim_hit[g]),
      .complete_i      (complete_hit[g]),
`ifdef IRQ_GW_CLAIM_TIMEOUT_EN
      .timeout_grant_i (timeout_grant[g]),
      .expired_o       (expired[g]),
`endif
      .pending_o       (pending[g]),
      .active_o        (active[g])
    );
  end

  // Strict compare while scanning upwards makes ties go to the lowest ID.
  always_comb begin
    best_id   = IdW'(IdNone);
    best_prio = '0;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      if (eligible[i] && (prio_of[i] > best_prio)) begin
        best_id   = IdW'(i + 1);
        best_prio = prio_of[i];
      end
    end
  end

  always_comb begin
    irq_d         = (best_id != IdW'(IdNone));
    claim_valid_d = claim_req_i;
    claim_id_d    = claim_req_i ? best_id : IdW'(IdNone);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q         <= 1'b0;
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
    end else begin
      irq_q         <= irq_d;
      claim_valid_q <= claim_valid_d;
      claim_id_q    <= claim_id_d;
    end
  end

  assign irq_o         = irq_q;
  assign claim_valid_o = claim_valid_q;
  assign claim_id_o    = claim_id_q;

`ifdef IRQ_GW_CLAIM_TIMEOUT_EN
  always_comb begin
    logic found;
    found         = 1'b0;
    timeout_grant = '0;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      if (expired[i] && !found) begin
        timeout_grant[i] = 1'b1;
        found            = 1'b1;
      end
    end
    timeout_d = found;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  logic unused_active;
  assign unused_active = ^active;

endmodule

// File: tb/tb_irq_gw_arb.sv
// Directed bench for irq_gw_arb: claims are checked by a scoreboard monitor,
// irq/timeout levels by direct checks. Timeout checks follow IRQ_GW_CLAIM_TIMEOUT_EN.
module tb_irq_gw_arb;

  localparam int NumSrc    = 4;
  localparam int PrioWidth = 2;
  localparam int IdW       = 3;

  logic                        clk_i = 1'b0;
  logic                        rst_ni = 1'b0;
  logic [NumSrc-1:0]           intr_src_i = '0;
  logic [NumSrc-1:0]           edge_mode_i = '0;
  logic [NumSrc-1:0]           ie_i = '0;
  logic [NumSrc*PrioWidth-1:0] prio_i = '0;
  logic [PrioWidth-1:0]        threshold_i = '0;
  logic                        claim_req_i = 1'b0;
  logic [IdW-1:0]              claim_id_o;
  logic                        claim_valid_o;
  logic                        complete_i = 1'b0;
  logic [IdW-1:0]              complete_id_i = '0;
  logic                        irq_o;
  logic                        timeout_o;

  int vectors     = 0;
  int miscompares = 0;
  logic [IdW-1:0] exp_q[$];

  irq_gw_arb #(.NumSrc(NumSrc), .PrioWidth(PrioWidth), .TimeoutW(4)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .intr_src_i    (intr_src_i),
    .edge_mode_i   (edge_mode_i),
    .ie_i          (ie_i),
    .prio_i        (prio_i),
    .threshold_i   (threshold_i),
    .claim_req_i   (claim_req_i),
    .claim_id_o    (claim_id_o),
    .claim_valid_o (claim_valid_o),
    .complete_i    (complete_i),
    .complete_id_i (complete_id_i),
    .irq_o         (irq_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every claim_valid pulse must match the next queued ID.
  always @(negedge clk_i) begin
    if (rst_ni && claim_valid_o) begin
      if (exp_q.size() == 0) begin
        check("claim_unexpected", 32'(claim_valid_o), 32'd0);
      end else begin
        check("claim_id", 32'(claim_id_o), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_claim(input logic [IdW-1:0] exp_id);
    claim_req_i = 1'b1;
    exp_q.push_back(exp_id);
    tick();
    claim_req_i = 1'b0;
  endtask

  task automatic do_complete(input logic [IdW-1:0] id);
    complete_i    = 1'b1;
    complete_id_i = id;
    tick();
    complete_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    edge_mode_i = 4'b0110;
    ie_i        = 4'b1111;
    prio_i      = 8'b10_11_01_10;  // src4=2, src3=3, src2=1, src1=2
    repeat (3) tick();
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_valid", 32'(claim_valid_o), 32'd0);
    check("rst_id", 32'(claim_id_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    // Level source 1: two-cycle latency, claim, complete with line high.
    intr_src_i[0] = 1'b1;
    tick();
    check("lvl_irq_lat1", 32'(irq_o), 32'd0);
    tick();
    check("lvl_irq_lat2", 32'(irq_o), 32'd1);
    do_claim(3'd1);
    tick();
    check("lvl_irq_drop", 32'(irq_o), 32'd0);
    do_complete(3'd1);
    tick();
    check("lvl_repend", 32'(irq_o), 32'd0);
    tick();
    check("lvl_reassert", 32'(irq_o), 32'd1);
    intr_src_i[0] = 1'b0;
    do_claim(3'd1);
    do_complete(3'd1);
    tick();

    // Edge sources 2 (prio 1) and 3 (prio 3): priority order, then empty claim.
    intr_src_i[2:1] = 2'b11;
    tick();
    tick();
    check("edge_irq", 32'(irq_o), 32'd1);
    do_claim(3'd3);
    do_claim(3'd2);
    do_claim(3'd0);
    tick();
    check("edge_all_active", 32'(irq_o), 32'd0);

    // Second edge on active source 2 sets re-arm; complete sends it to PEND.
    intr_src_i[1] = 1'b0;
    tick();
    intr_src_i[1] = 1'b1;
    tick();
    tick();
    check("rearm_no_irq", 32'(irq_o), 32'd0);
    do_complete(3'd2);
    check("rearm_irq_pre", 32'(irq_o), 32'd0);
    tick();
    check("rearm_irq", 32'(irq_o), 32'd1);

    // Same-cycle claim of 2 and complete of 3.
    claim_req_i   = 1'b1;
    complete_i    = 1'b1;
    complete_id_i = 3'd3;
    exp_q.push_back(3'd2);
    tick();
    claim_req_i = 1'b0;
    complete_i  = 1'b0;
    do_complete(3'd2);
    tick();
    tick();
    check("claim_cmpl_idle", 32'(irq_o), 32'd0);
    intr_src_i[2:1] = 2'b00;
    tick();

    // Edge on source 3 in the same cycle it is claimed: ACTIVE plus re-arm.
    intr_src_i[2] = 1'b1;
    tick();
    intr_src_i[2] = 1'b0;
    tick();
    intr_src_i[2] = 1'b1;
    do_claim(3'd3);
    tick();
    check("trig_claim_active", 32'(irq_o), 32'd0);
    do_complete(3'd3);
    tick();
    check("trig_claim_rearm", 32'(irq_o), 32'd1);
    intr_src_i[2] = 1'b0;
    do_claim(3'd3);
    do_complete(3'd3);
    tick();
    tick();
    check("trig_claim_idle", 32'(irq_o), 32'd0);

    // Tie between sources 1 and 4 (both prio 2): lowest ID first.
    intr_src_i[0] = 1'b1;
    intr_src_i[3] = 1'b1;
    tick();
    tick();
    do_claim(3'd1);
    do_claim(3'd4);
    intr_src_i[0] = 1'b0;
    intr_src_i[3] = 1'b0;
    do_complete(3'd1);
    do_complete(3'd4);
    tick();

    // Threshold, bogus completes, disable while pending.
    threshold_i   = 2'd2;
    intr_src_i[0] = 1'b1;
    repeat (3) tick();
    check("thr_block", 32'(irq_o), 32'd0);
    threshold_i = 2'd1;
    tick();
    check("thr_lower", 32'(irq_o), 32'd1);
    do_complete(3'd5);
    do_complete(3'd2);
    tick();
    check("bad_cmpl_irq", 32'(irq_o), 32'd1);
    ie_i[0] = 1'b0;
    tick();
    tick();
    check("ie_off", 32'(irq_o), 32'd0);
    ie_i[0] = 1'b1;
    tick();
    check("ie_on_still_pend", 32'(irq_o), 32'd1);
    do_claim(3'd1);
    intr_src_i[0] = 1'b0;
    do_complete(3'd1);
    threshold_i = 2'd0;
    tick();

    // Asynchronous reset mid-operation.
    intr_src_i[0] = 1'b1;
    tick();
    tick();
    check("pre_rst_irq", 32'(irq_o), 32'd1);
    intr_src_i[0] = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_irq", 32'(irq_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    tick();
    check("post_rst_idle", 32'(irq_o), 32'd0);

    // Claim watchdog.
    intr_src_i[0] = 1'b1;
    tick();
    tick();
    do_claim(3'd1);
`ifdef IRQ_GW_CLAIM_TIMEOUT_EN
    repeat (15) tick();
    check("to_not_yet", 32'(timeout_o), 32'd0);
    tick();
    check("to_pulse", 32'(timeout_o), 32'd1);
    tick();
    check("to_pulse_end", 32'(timeout_o), 32'd0);
    tick();
    check("to_repend", 32'(irq_o), 32'd1);
    intr_src_i[0] = 1'b0;
    do_claim(3'd1);
    do_complete(3'd1);
`else
    repeat (20) tick();
    check("to_absent", 32'(timeout_o), 32'd0);
    do_claim(3'd0);
    intr_src_i[0] = 1'b0;
    do_complete(3'd1);
`endif
    repeat (3) tick();
    check("final_irq", 32'(irq_o), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/irq_gw_arb.md
Name: irq_gw_arb

Overview:
- Interrupt gateway and priority arbiter sitting directly downstream of the GPIO block.
- Consumes the GPIO interrupt lines (and any other peripheral interrupt lines) and latches them per source as pending.
- Selects the highest-priority enabled pending source above a threshold and drives a single core interrupt.
- Offers a claim/complete handshake so the core owns one source at a time until it completes it.

Parameters:
- NumSrc, 4, number of interrupt sources; IDs are 1..NumSrc, ID 0 means "none".
- PrioWidth, 2, bits of priority per source; priority 0 means never eligible.
- TimeoutW, 8, width of the claim watchdog counter (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- intr_src_i  in  NumSrc  raw interrupt lines.
- edge_mode_i  in  NumSrc  per source: 1 = rising-edge triggered, 0 = level (active-high).
- ie_i  in  NumSrc  per-source enable.
- prio_i  in  NumSrc*PrioWidth  priorities; source k occupies bits [k*PrioWidth +: PrioWidth].
- threshold_i  in  PrioWidth  only priorities strictly greater than this value are eligible.
- claim_req_i  in  1  single-cycle claim strobe from the core.
- claim_id_o  out  IdW  claimed ID (registered); IdW = $clog2(NumSrc+1).
- claim_valid_o  out  1  one-cycle pulse qualifying claim_id_o.
- complete_i  in  1  single-cycle completion strobe.
- complete_id_i  in  IdW  ID being completed.
- irq_o  out  1  registered core interrupt.
- timeout_o  out  1  one-cycle watchdog pulse (optional feature only).

Behaviour:
- Reset values: all outputs 0; all gateways IDLE; all re-arm bits 0; edge history registers 0.
- Per-source gateway states: IDLE, PEND, ACTIVE.
  - IDLE->PEND on trigger. Trigger is an edge (src & ~src_q) in edge mode, or src high in level mode.
  - PEND->ACTIVE when the source is claimed.
  - ACTIVE->IDLE on a complete whose ID matches.
- Edge mode, edge while PEND: merged, no extra state.
- Edge mode, edge while ACTIVE: sets a re-arm bit. On complete, a set re-arm bit sends the source ACTIVE->PEND and clears the bit.
- Level mode while ACTIVE: the line is ignored. After complete the source re-enters PEND on the next cycle if the line is still high.
- Eligibility: state==PEND && ie && prio > threshold.
- Arbitration is combinational: highest prio wins; ties go to the lowest ID; best_id = 0 when nothing is eligible.
- irq_o is registered: irq_o(t+1) = (best_id != 0)(t). Latency from trigger edge to irq_o is 2 cycles (pending reg, then irq reg).
- Claim timing: claim_req_i at cycle t samples best_id(t). At t+1, claim_id_o = best_id(t) and claim_valid_o = 1.
  - If best_id(t) != 0, that gateway goes PEND->ACTIVE at t+1.
  - If best_id(t) = 0, the claim returns ID 0 with valid=1 and changes no state.
- Multiple outstanding ACTIVE sources are legal (nested claims).
- Complete is ignored when the ID is 0, greater than NumSrc, or the target is not ACTIVE.
- Same-cycle claim and complete: both apply. The complete is evaluated on the pre-claim state. A source completed this cycle cannot be claimed this cycle; best_id was computed from state at t.
- Same-cycle trigger and claim of the same source (edge mode): the source goes ACTIVE and the re-arm bit is set.
- ie_i or prio_i changes affect eligibility only, never the state. Disabling a PEND source leaves it pending.
- Reset asserted mid-operation: everything returns to reset values immediately (async).

Optional Feature:
- Macro: IRQ_GW_CLAIM_TIMEOUT_EN.
- Defined:
  - Each source has a TimeoutW-bit counter that runs while ACTIVE and clears on leaving ACTIVE.
  - When the counter reaches all-ones, the source is auto-completed (same rules as a real complete, including re-arm).
  - timeout_o pulses for 1 cycle. The lowest ID wins if several expire in the same cycle; the others expire on following cycles.
- Undefined: no counters; timeout_o tied 0; a source stays ACTIVE indefinitely until completed.

Decomposition:
- Package irq_gw_pkg holds:
  - gw_state_e enum {GwIdle, GwPend, GwActive} (2-bit).
  - function id_width(n) returning $clog2(n+1).
  - localparam IdNone = 0.
- Sub-module irq_gw_src: one per source via generate.
  - Contains the edge detect, state FSM, re-arm bit and optional timeout counter.
  - Outputs pending_o and active_o.
- The arbiter tree, claim and irq registers live in the top.

Test Plan:
- Level source 1, prio 2, threshold 0, ie=1; raise intr_src_i[0] -> irq_o=1 two cycles later. Claim -> claim_id_o=1, valid pulse, irq_o drops. Complete with line still high -> irq_o reasserts 2 cycles later.
- Edge sources 2 (prio 1) and 3 (prio 3) raised together -> claim returns 3. Then claim returns 2. A third claim returns 0 with valid=1.
- Tie: sources 1 and 4 both prio 2 and pending -> claim returns 1.
- Edge source 2 claimed, second rising edge while ACTIVE -> no irq_o. Complete(2) -> PEND, irq_o=1 after 1 cycle (irq reg).
- threshold_i=2 with source prio 2 pending -> irq_o stays 0. Lowering the threshold to 1 -> irq_o=1 next cycle. Complete(5) and complete of an IDLE ID -> no state change.
- With IRQ_GW_CLAIM_TIMEOUT_EN and TimeoutW=4: claim source 1, no complete -> timeout_o pulses after 15 ACTIVE cycles. Source 1 returns to IDLE, or to PEND if the level line is still high.
